// File: rtl/alu_unit.sv
// Registered 32-bit integer ALU for the execute stage: one result and a
// {ZF,SF,CF,OF} flag vector per cycle, both available one clock after the operands.
module alu_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] lhs,
   input  logic [WIDTH-1:0] rhs,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] res,
   output logic [3:0]       flags
);

   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SLL  = 4'b0001,
      OP_SLT  = 4'b0010,
      OP_SLTU = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SRL  = 4'b0101,
      OP_OR   = 4'b0110,
      OP_AND  = 4'b0111,
      OP_SUB  = 4'b1000,
      OP_SRA  = 4'b1001,
      OP_ADDU = 4'b1010,
      OP_SUBU = 4'b1011
   } aluOp_e;

   aluOp_e            opSel;
   logic              useSub;
   logic [WIDTH-1:0]  rhsEff;
   logic [WIDTH-1:0]  sum;
   logic              carryOut;
   logic              signedOvf;
   logic              lessSigned;
   logic              lessUnsigned;
   logic [SHW-1:0]    shamt;
   logic              shiftFill;
   logic [WIDTH-1:0]  shiftIn;
   logic [WIDTH-1:0]  shiftRight;
   logic [WIDTH-1:0]  shiftRes;
   logic [WIDTH-1:0]  res_d;
   logic [WIDTH-1:0]  res_q;
   logic [3:0]        flags_d;
   logic [3:0]        flags_q;

   assign opSel = aluOp_e'(op);

   function automatic logic [WIDTH-1:0] reverseBits(input logic [WIDTH-1:0] value);
      logic [WIDTH-1:0] rev;
      rev = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rev[i] = value[MSB-i];
      end
      return rev;
   endfunction

   // One adder serves add/sub and both compares; compares run it in subtract mode.
   always_comb begin
      useSub = (opSel == OP_SUB) || (opSel == OP_SUBU) ||
               (opSel == OP_SLT) || (opSel == OP_SLTU);
      rhsEff = useSub ? ~rhs : rhs;
      {carryOut, sum} = {1'b0, lhs} + {1'b0, rhsEff} + {{WIDTH{1'b0}}, useSub};
      signedOvf    = (lhs[MSB] == rhsEff[MSB]) && (sum[MSB] != lhs[MSB]);
      lessSigned   = sum[MSB] ^ signedOvf;
      lessUnsigned = ~carryOut;
   end

   // Single right-shifting log shifter; left shifts go through bit reversal.
   always_comb begin
      shamt      = rhs[SHW-1:0];
      shiftFill  = (opSel == OP_SRA) && lhs[MSB];
      shiftIn    = (opSel == OP_SLL) ? reverseBits(lhs) : lhs;
      shiftRight = shiftIn;
      for (int s = 0; s < SHW; s++) begin
         if (shamt[s]) begin
            shiftRight = shiftFill ? ~((~shiftRight) >> (1 << s)) : (shiftRight >> (1 << s));
         end
      end
      shiftRes = (opSel == OP_SLL) ? reverseBits(shiftRight) : shiftRight;
   end

   // Result select; the four unassigned opcodes fall through to zero.
   always_comb begin
      res_d = '0;
      case (opSel)
         OP_ADD, OP_ADDU, OP_SUB, OP_SUBU: res_d = sum;
         OP_SLL, OP_SRL, OP_SRA:           res_d = shiftRes;
         OP_SLT:                           res_d = {{(WIDTH-1){1'b0}}, lessSigned};
         OP_SLTU:                          res_d = {{(WIDTH-1){1'b0}}, lessUnsigned};
         OP_XOR:                           res_d = lhs ^ rhs;
         OP_OR:                            res_d = lhs | rhs;
         OP_AND:                           res_d = lhs & rhs;
         default:                          res_d = '0;
      endcase
   end

   // Carry means borrow for subtraction; only the signed forms report overflow.
   always_comb begin
      flags_d    = 4'b0000;
      flags_d[3] = (res_d == '0);
      flags_d[2] = res_d[MSB];
      case (opSel)
         OP_ADD:  begin flags_d[1] = carryOut;     flags_d[0] = signedOvf; end
         OP_ADDU: begin flags_d[1] = carryOut;                             end
         OP_SUB:  begin flags_d[1] = lessUnsigned; flags_d[0] = signedOvf; end
         OP_SUBU: begin flags_d[1] = lessUnsigned;                         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_q   <= '0;
         flags_q <= 4'b0000;
      end else begin
         res_q   <= res_d;
         flags_q <= flags_d;
      end
   end

   assign res   = res_q;
   assign flags = flags_q;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed vectors with hand-computed answers, then random
// traffic compared every cycle against an arithmetic reference model.
module tb_alu_unit;

   localparam logic [3:0] ADD = 4'b0000, SLL = 4'b0001, SLT = 4'b0010, SLTU = 4'b0011,
                          XOR = 4'b0100, SRL = 4'b0101, OR = 4'b0110, AND = 4'b0111,
                          SUB = 4'b1000, SRA = 4'b1001, ADDU = 4'b1010, SUBU = 4'b1011;

   logic        clk;
   logic        rst;
   logic [31:0] lhs;
   logic [31:0] rhs;
   logic [3:0]  op;
   logic [31:0] res;
   logic [3:0]  flags;

   int          nCompared;
   int          nMismatched;
   logic [31:0] expRes;
   logic [3:0]  expFlags;
   logic        modelValid;

   alu_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .lhs   (lhs),
      .rhs   (rhs),
      .op    (op),
      .res   (res),
      .flags (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain wide arithmetic, returns {res, ZF, SF, CF, OF}.
   function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] o);
      logic [31:0] r;
      logic        cf;
      logic        of;
      longint      ua;
      longint      ub;
      longint      sa;
      longint      sb;
      longint      t;
      int          sh;
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b[4:0]);
      r  = 32'h0;
      cf = 1'b0;
      of = 1'b0;
      case (o)
         ADD, ADDU: begin
            r  = a + b;
            cf = (ua + ub) > 64'sd4294967295;
            t  = sa + sb;
            if (o == ADD) of = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         SUB, SUBU: begin
            r  = a - b;
            cf = ua < ub;
            t  = sa - sb;
            if (o == SUB) of = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         SLL:  r = a << sh;
         SRL:  r = a >> sh;
         SRA:  r = $signed(a) >>> sh;
         SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
         SLTU: r = (ua < ub) ? 32'd1 : 32'd0;
         XOR:  r = a ^ b;
         OR:   r = a | b;
         AND:  r = a & b;
         default: r = 32'h0;
      endcase
      return {r, (r == 32'h0), r[31], cf, of};
   endfunction

   // Model register mirrors the one-cycle latency and reset behaviour.
   always @(posedge clk) begin
      if (rst) begin
         expRes   <= 32'h0;
         expFlags <= 4'b0000;
      end else begin
         {expRes, expFlags} <= model(lhs, rhs, op);
      end
      modelValid <= 1'b1;
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (modelValid === 1'b1) begin
         nCompared++;
         if (res !== expRes || flags !== expFlags) begin
            nMismatched++;
            $display("[TB] FAIL cycle@%0t: res=%h flags=%b, expected res=%h flags=%b",
                     $time, res, flags, expRes, expFlags);
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o);
      lhs = a;
      rhs = b;
      op  = o;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] wantRes, input logic [3:0] wantFlags);
      nCompared++;
      if (res !== wantRes || flags !== wantFlags) begin
         nMismatched++;
         $display("[TB] FAIL %s: res=%h flags=%b, expected res=%h flags=%b",
                  name, res, flags, wantRes, wantFlags);
      end
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      modelValid  = 1'b0;
      rst = 1'b1;
      lhs = 32'h1234_5678;
      rhs = 32'h0000_0001;
      op  = ADD;
      @(posedge clk);
      #1;
      applyStimulus(32'h1234_5678, 32'h0000_0001, ADD);
      checkOutput("reset", 32'h0, 4'b0000);
      rst = 1'b0;

      applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, ADD);  checkOutput("add_carry", 32'h0000_0000, 4'b1010);
      applyStimulus(32'h7FFF_FFFF, 32'h7000_0001, ADD);  checkOutput("add_ovf",   32'hF000_0000, 4'b0101);
      applyStimulus(32'h7FFF_FFFF, 32'hF000_0001, ADD);  checkOutput("add_mixed", 32'h7000_0000, 4'b0010);
      applyStimulus(32'h7FFF_FFFF, 32'h7000_0001, ADDU); checkOutput("addu_noovf", 32'hF000_0000, 4'b0100);
      applyStimulus(32'h0000_0000, 32'h0000_0001, SUB);  checkOutput("sub_borrow", 32'hFFFF_FFFF, 4'b0110);
      applyStimulus(32'h7FFF_FFFF, 32'hF000_0001, SUB);  checkOutput("sub_ovf",   32'h8FFF_FFFE, 4'b0111);
      applyStimulus(32'h7FFF_FFFF, 32'hF000_0001, SUBU); checkOutput("subu",      32'h8FFF_FFFE, 4'b0110);
      applyStimulus(32'h000F_0000, 32'h0000_0002, SLL);  checkOutput("sll2",      32'h003C_0000, 4'b0000);
      applyStimulus(32'h7FFF_FFFF, 32'h0000_0004, SLL);  checkOutput("sll4",      32'hFFFF_FFF0, 4'b0100);
      applyStimulus(32'h7FFF_FFFF, 32'h0000_0003, SRL);  checkOutput("srl3",      32'h0FFF_FFFF, 4'b0000);
      applyStimulus(32'h800000F0, 32'h0000_0004, SRA);   checkOutput("sra_neg",   32'hF800_000F, 4'b0100);
      applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, SRA);  checkOutput("sra_pos",   32'h3FFF_FFFF, 4'b0000);
      applyStimulus(32'h8765_4321, 32'hFFFF_FFE0, SLL);  checkOutput("sll_zero_amt", 32'h8765_4321, 4'b0100);
      applyStimulus(32'h8000_0000, 32'hABCD_EF3F, SRA);  checkOutput("sra_upper_ignored", 32'hFFFF_FFFF, 4'b0100);
      applyStimulus(32'h7FFF_FFFF, 32'hF000_0001, SLT);  checkOutput("slt",       32'h0000_0000, 4'b1000);
      applyStimulus(32'h7FFF_FFFF, 32'hF000_0001, SLTU); checkOutput("sltu",      32'h0000_0001, 4'b0000);
      applyStimulus(32'h0005_0000, 32'h0003_0001, SLT);  checkOutput("slt_pos",   32'h0000_0000, 4'b1000);
      applyStimulus(32'h7FFF_FFFF, 32'hF000_0001, XOR);  checkOutput("xor",       32'h8FFF_FFFE, 4'b0100);
      applyStimulus(32'h7FFF_FFFF, 32'hF000_0001, OR);   checkOutput("or",        32'hFFFF_FFFF, 4'b0100);
      applyStimulus(32'h7FFF_FFFF, 32'hF000_0001, AND);  checkOutput("and",       32'h7000_0001, 4'b0000);
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111); checkOutput("unused_op", 32'h0, 4'b1000);

      rst = 1'b1;
      applyStimulus(32'h7FFF_FFFF, 32'h7000_0001, ADD);
      checkOutput("reset_midstream", 32'h0, 4'b0000);
      rst = 1'b0;
      applyStimulus(32'h7FFF_FFFF, 32'h7000_0001, ADD);
      checkOutput("after_reset", 32'hF000_0000, 4'b0101);

      // Random traffic with occasional reset pulses; the negedge checker does the work.
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         applyStimulus(pickOperand(), pickOperand(), 4'($urandom_range(0, 15)));
      end
      rst = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
